// File: rtl/seg7_scan_driver_if.sv
// Digit/display bus between the time source and the seven-segment scan driver.
// The master supplies BCD digits and control; the slave returns the cathode/anode drive.
interface seg7_scan_driver_if;
  logic [23:0] digit_in;
  logic        tick_1hz;
  logic        blank_lead;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;

  modport master (
    output digit_in, tick_1hz, blank_lead,
    input  seg, dp, an
  );

  modport slave (
    input  digit_in, tick_1hz, blank_lead,
    output seg, dp, an
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Six-digit common-anode scan driver: frame-coherent snapshot of the BCD time,
// per-slot anti-ghost blanking, hour-tens zero suppression and a toggling colon.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input logic               clk,
  input logic               reset,
  seg7_scan_driver_if.slave bus
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] slot_cnt, slot_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [23:0]      shadow, shadow_nxt;
  logic             colon_on, colon_nxt;

  logic [6:0] seg_p1, seg_nxt;
  logic       dp_p1, dp_nxt;
  logic [5:0] an_p1, an_nxt;
  logic [3:0] digit;
  logic       slot_end;

  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg7_decode = 7'b1000000;
      4'd1:    seg7_decode = 7'b1111001;
      4'd2:    seg7_decode = 7'b0100100;
      4'd3:    seg7_decode = 7'b0110000;
      4'd4:    seg7_decode = 7'b0011001;
      4'd5:    seg7_decode = 7'b0010010;
      4'd6:    seg7_decode = 7'b0000010;
      4'd7:    seg7_decode = 7'b1111000;
      4'd8:    seg7_decode = 7'b0000000;
      4'd9:    seg7_decode = 7'b0010000;
      default: seg7_decode = 7'b0111111;
    endcase
  endfunction

  // State register: scan position, snapshot, colon and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      slot_cnt <= '0;
      idx      <= 3'd0;
      shadow   <= 24'h0;
      colon_on <= 1'b1;
      seg_p1   <= 7'b1111111;
      dp_p1    <= 1'b1;
      an_p1    <= 6'b111111;
    end else begin
      slot_cnt <= slot_nxt;
      idx      <= idx_nxt;
      shadow   <= shadow_nxt;
      colon_on <= colon_nxt;
      seg_p1   <= seg_nxt;
      dp_p1    <= dp_nxt;
      an_p1    <= an_nxt;
    end
  end

  // Next-state: slot/digit walk; the snapshot is taken only at the frame boundary
  always_comb begin
    slot_end   = (slot_cnt == LAST);
    slot_nxt   = slot_end ? '0 : slot_cnt + 1'b1;
    idx_nxt    = idx;
    if (slot_end) idx_nxt = (idx == 3'd5) ? 3'd0 : idx + 3'd1;
    shadow_nxt = (slot_end && idx == 3'd5) ? bus.digit_in : shadow;
    colon_nxt  = colon_on ^ bus.tick_1hz;
  end

  // Output decode from the current scan position, registered one cycle later
  always_comb begin
    case (idx)
      3'd0:    digit = shadow[23:20];
      3'd1:    digit = shadow[19:16];
      3'd2:    digit = shadow[15:12];
      3'd3:    digit = shadow[11:8];
      3'd4:    digit = shadow[7:4];
      3'd5:    digit = shadow[3:0];
      default: digit = 4'h0;
    endcase
    seg_nxt = seg7_decode(digit);
    dp_nxt  = !(((idx == 3'd1) || (idx == 3'd3)) && colon_on);
    an_nxt  = 6'b111111;
    if (!(slot_cnt < BLANK) &&
        !((idx == 3'd0) && bus.blank_lead && (shadow[23:20] == 4'h0)))
      an_nxt = ~(6'b000001 << idx);
  end

  assign bus.seg = seg_p1;
  assign bus.dp  = dp_p1;
  assign bus.an  = an_p1;

endmodule
